// File: rtl/uart_receive.sv
// 8N1 UART receiver. A 2-flop synchronizer feeds a start-edge detector. An
// oversampling tick generator is phase-aligned to the detected edge. Each bit
// is decided by a 2-of-3 majority vote around mid-bit. Each byte is reported
// with a one-cycle valid pulse; a low stop bit gives a one-cycle frame_err pulse.
//
// Output handshake: valid and frame_err are single-cycle strobes with no ready
// back-pressure. dout is stable from the valid cycle until the next valid.
// The two strobes are mutually exclusive.
module uart_receive #(
  parameter int CLK_FREQ   = 65_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic            rxd_m, rxd_s, rxd_d;
  logic [TW-1:0]   tick_cnt;
  logic [SW-1:0]   sub_cnt;
  logic [2:0]      bit_cnt;
  logic            smp0, smp1;
  logic [7:0]      shreg;
  logic            fall, tick, mid, vote;
  logic            shift_en, load_dout, set_err;

  // Bring rxd into the clk domain; rxd_d is the one-cycle delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  assign fall = rxd_d & ~rxd_s;
  assign tick = (state_q != IDLE) && (tick_cnt == T_LAST);
  assign mid  = tick && (sub_cnt == S_HI);
  assign vote = (smp0 & smp1) | (smp0 & rxd_s) | (smp1 & rxd_s);
  assign busy = (state_q != IDLE);

  // Next-state logic and per-cycle control strobes for the frame FSM.
  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    load_dout = 1'b0;
    set_err   = 1'b0;
    case (state_q)
      IDLE:  if (fall) state_d = START;
      START: if (mid) state_d = vote ? IDLE : DATA;
      DATA: begin
        if (mid) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leave at stop mid-bit so a slightly early next start edge is still caught.
        if (mid) begin
          state_d = IDLE;
          if (vote) load_dout = 1'b1;
          else      set_err   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Tick, sub-bit and bit counters; all held at zero while idle so timing restarts at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      sub_cnt  <= '0;
      bit_cnt  <= '0;
    end else if (state_q == IDLE) begin
      tick_cnt <= '0;
      sub_cnt  <= '0;
      bit_cnt  <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (tick) sub_cnt <= (sub_cnt == S_LAST) ? '0 : sub_cnt + SW'(1);
      if (shift_en) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Capture the first two majority samples; the third is rxd_s at the decision tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp0 <= 1'b1;
      smp1 <= 1'b1;
    end else if (tick) begin
      if (sub_cnt == S_LO)  smp0 <= rxd_s;
      if (sub_cnt == S_MID) smp1 <= rxd_s;
    end
  end

  // Shift register (LSB first on the line) and registered output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= 8'h00;
      dout      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (shift_en)  shreg <= {vote, shreg[7:1]};
      if (load_dout) dout  <= shreg;
      valid     <= load_dout;
      frame_err <= set_err;
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Testbench for uart_receive: the bench drives serial frames and a scoreboard
// queue holds the expected byte or error for each complete frame. A monitor
// compares every valid/frame_err pulse against that queue and also checks the
// latency of each pulse.
module tb_uart_receive;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int BAUD_RATE  = 10_000;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLKS   = CLK_FREQ / BAUD_RATE;                 // 160
  localparam int TICK_CLKS  = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);  // 10
  localparam int LATENCY    = 3 + 9 * BIT_CLKS + (OVERSAMPLE / 2 + 2) * TICK_CLKS;

  logic       clk, rst_n, rxd;
  logic [7:0] dout;
  logic       valid, frame_err, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [8:0] exp_q[$];   // {is_error, expected dout}
  int         start_q[$]; // cycle of the falling edge for that frame
  logic [7:0] last_good = 8'h00;
  logic       valid_prev = 1'b0;

  uart_receive #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .dout(dout),
    .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1 rxd = 1'b1;
    end
  endtask

  // Drive one 8N1 frame. spike_at inverts the line for one clk at that frame cycle;
  // abort_at pulses reset there and abandons the frame; hold_low extends a low line.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int spike_at, input int abort_at, input int hold_low);
    logic [9:0] bits;
    logic       v;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10 * BIT_CLKS; i++) begin
      @(posedge clk); #1;
      if (i == abort_at) begin
        rxd   = 1'b1;
        rst_n = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("rst_dout", dout, 8'h00);
          check("rst_valid", valid, 0);
          check("rst_frame_err", frame_err, 0);
          check("rst_busy", busy, 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
      v = bits[i / BIT_CLKS];
      if (i == spike_at) v = ~v;
      rxd = v;
      if (i == 0 && abort_at < 0) begin
        if (stop_bit) begin
          exp_q.push_back({1'b0, b});
          last_good = b;
        end else begin
          exp_q.push_back({1'b1, last_good});
        end
        start_q.push_back(cyc);
      end
    end
    repeat (hold_low) begin
      @(posedge clk); #1 rxd = 1'b0;
    end
  endtask

  // Short low glitch: the start bit must be rejected at its mid-bit.
  task automatic glitch();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1 rxd = (i < 30) ? 1'b0 : 1'b1;
      if (i == 60) begin
        @(negedge clk); check("glitch_busy_high", busy, 1);
      end
      if (i == 120) begin
        @(negedge clk); check("glitch_busy_low", busy, 0);
      end
    end
  endtask

  // Monitor: every output pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid || frame_err) begin
        check("exclusive", {31'd0, valid && frame_err}, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got valid=%0d frame_err=%0d dout=%0h required no pulse",
                   valid, frame_err, dout);
        end else begin
          logic [8:0] e;
          int         s, lat;
          e   = exp_q.pop_front();
          s   = start_q.pop_front();
          lat = cyc - s;
          check("pulse_data", {23'd0, frame_err, dout}, {23'd0, e});
          n_checks++;
          if (lat < LATENCY - 1 || lat > LATENCY + 1) begin
            n_fail++;
            $display("FAIL latency: got %0d required %0d..%0d", lat, LATENCY - 1, LATENCY + 1);
          end
          check("busy_at_pulse", busy, 0);
        end
      end
      if (valid) check("valid_width", {31'd0, valid_prev}, 0);
      valid_prev <= valid;
    end
  end

  initial begin
    int wait_cnt;
    logic [7:0] rb;
    logic       rerr;
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_dout", dout, 8'h00);
    check("reset_valid", valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_busy", busy, 0);
    #1 rst_n = 1'b1;
    idle(50);

    // Single byte.
    send_frame(8'hA5, 1'b1, -1, -1, 0);
    idle(100);

    // Back-to-back with no idle gap.
    send_frame(8'h00, 1'b1, -1, -1, 0);
    send_frame(8'hFF, 1'b1, -1, -1, 0);
    idle(100);

    // Glitch followed by a good frame.
    glitch();
    send_frame(8'h3C, 1'b1, -1, -1, 0);
    idle(100);

    // Framing error with break, then recovery.
    send_frame(8'h3C, 1'b0, -1, -1, 2 * BIT_CLKS);
    @(negedge clk);
    check("break_busy", busy, 0);
    check("break_dout_kept", dout, 8'h3C);
    idle(100);
    send_frame(8'h81, 1'b1, -1, -1, 0);
    idle(100);

    // One-clk spike on the tick-8 sample of data bit 3 (frame cycle 4*160+90).
    send_frame(8'h55, 1'b1, 4 * BIT_CLKS + 90, -1, 0);
    idle(100);

    // Reset in the middle of data bit 4, then a clean frame.
    send_frame(8'h96, 1'b1, -1, 5 * BIT_CLKS + 40, 0);
    last_good = 8'h00;
    idle(300);
    send_frame(8'hC3, 1'b1, -1, -1, 0);
    idle(100);

    // Random bytes, occasional framing errors, random gaps.
    for (int r = 0; r < 6; r++) begin
      rb   = 8'($urandom_range(0, 255));
      rerr = ($urandom_range(0, 3) == 0);
      send_frame(rb, ~rerr, -1, -1, 0);
      idle(rerr ? int'($urandom_range(20, 100)) : int'($urandom_range(0, 100)));
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 4000) begin
      @(posedge clk);
      wait_cnt++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending pulses required 0", exp_q.size());
    end
    idle(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receive.md
Name: uart_receive

Overview:
UART receiver for 8N1 serial frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Samples the asynchronous rxd line, validates the start bit, recovers one byte per frame.
- Presents each byte with a single-cycle valid strobe.
- Sits beside the UART transmitter in the uart block; fabric-side logic consumes dout/valid directly, with no buffering.

Parameters:
CLK_FREQ, 65_000_000, system clock frequency in Hz
BAUD_RATE, 115200, serial bit rate in bit/s
OVERSAMPLE, 16, sample ticks per bit period; must be even and >= 8

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rxd  input  1  UART_RXD serial line, asynchronous to clk, idle high
dout  output  8  last correctly received byte
valid  output  1  one-cycle pulse: dout updated with a new byte
frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded
busy  output  1  high while a frame is being received (any state other than IDLE)

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. Reset values:
  - dout=8'h00, valid=0, frame_err=0, busy=0.
  - State=IDLE; tick and bit counters = 0; synchronizer flops = 1.
  - Reset asserted mid-frame aborts the frame immediately, with no valid or frame_err pulse.
- Input synchronization:
  - rxd passes through a 2-flop synchronizer reset to 1, giving rxd_s.
  - A third flop holds rxd_s delayed one cycle, for edge detection.
- Tick generation:
  - TICK_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer truncation.
  - The tick counter counts 0..TICK_DIV-1 and emits a one-clk tick on wrap.
  - It is held at 0 in IDLE and starts on the start-edge cycle, so ticks are phase-aligned to the detected falling edge.
- Sub-bit counter:
  - Counts ticks 0..OVERSAMPLE-1 within each bit and wraps to 0 at bit end.
- Majority vote:
  - rxd_s is captured at tick indices OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the 2-of-3 majority.
  - The decision is taken on tick index OVERSAMPLE/2+1, called the mid-bit point.
- FSM states:
  - IDLE: busy=0. A falling edge (delayed rxd_s=1 and rxd_s=0) moves to START. A line held low never retriggers; a 1->0 edge is required.
  - START: at mid-bit, majority=0 → DATA with bit count 0; majority=1 → false start, back to IDLE with no pulse.
  - DATA: at each mid-bit, the majority bit shifts in at the MSB (shift register right-shift, LSB first on the line). After the 8th bit (count=7), move to STOP.
  - STOP: at mid-bit, majority=1 → dout <= shift register, valid=1 for exactly one clk, go to IDLE. Majority=0 → frame_err=1 for one clk, dout unchanged, go to IDLE.
- Early return to IDLE:
  - The FSM returns to IDLE at stop mid-bit, not at the end of the stop bit.
  - This allows a following start edge up to half a bit early, giving baud-mismatch tolerance.
- Break condition: after frame_err with rxd still low, the receiver stays in IDLE until a fresh 1->0 edge.
- valid and frame_err are never high in the same cycle.
- Latency: valid rises (2 sync + 1) clk + 9 bit periods + (OVERSAMPLE/2+2) ticks after the rxd falling edge, ±1 clk.

Test Plan:
- Bench parameters: CLK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16, giving TICK_DIV=10 and 160 clk per bit.
1. Send 0xA5 (8N1) → exactly one valid pulse of 1 clk, dout=8'hA5, frame_err=0. valid falls within the latency window above; busy drops the same cycle valid rises.
2. Back-to-back 0x00 then 0xFF with no idle gap between the stop bit and the next start bit → two valid pulses, dout=8'h00 then 8'hFF, no frame_err.
3. Glitch: rxd low for 30 clk (3 ticks), then high → no valid, no frame_err; busy returns to 0 at start mid-bit; a following 0x3C is received correctly.
4. Frame 0x3C with the stop bit driven low, and rxd held low for 2 more bit periods → one frame_err pulse, no valid, dout keeps its previous value. A subsequent normal 0x81 then yields valid with dout=8'h81.
5. Noise: send 0x55 with a 1-clk inverted spike on the sample at tick index 8 of data bit 3 → majority vote corrects it, dout=8'h55.
6. Assert rst_n low for 5 clk during data bit 4 of a frame → outputs are 0 during reset; no pulse for the aborted frame; the next frame 0xC3 is received with dout=8'hC3.
